// File: rtl/binary_packer.sv
// Packs a 1-bit pixel stream into pack_width-bit words, flushing a zero-padded
// partial word at the end of every line_width-pixel line.
module binary_packer #(
  parameter int pack_width = 8,
  parameter int line_width = 640,
  parameter bit msb_first  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_enable,
  input  logic                  in_data,
  output logic                  out_ready,
  output logic [pack_width-1:0] out_data,
  output logic                  out_last
);

  localparam int bit_w = (pack_width > 1) ? $clog2(pack_width) : 1;
  localparam int col_w = (line_width > 1) ? $clog2(line_width) : 1;
  localparam logic [bit_w-1:0] bit_max = bit_w'(pack_width - 1);
  localparam logic [col_w-1:0] col_max = col_w'(line_width - 1);

  logic [bit_w-1:0]      bit_cnt_reg;
  logic [col_w-1:0]      col_cnt_reg;
  logic [pack_width-1:0] shift_reg;
  logic [pack_width-1:0] word_next;
  logic [pack_width-1:0] out_data_reg;
  logic                  out_ready_reg;
  logic                  out_last_reg;
  logic                  line_done;
  logic                  word_done;

  assign line_done = (col_cnt_reg == col_max);
  assign word_done = (bit_cnt_reg == bit_max) || line_done;

  // Word as it would look with the current pixel merged in at its slot.
  generate
    for (genvar gi = 0; gi < pack_width; gi++) begin : g_insert
      localparam logic [bit_w-1:0] slot =
        msb_first ? bit_w'(pack_width - 1 - gi) : bit_w'(gi);
      assign word_next[gi] = shift_reg[gi] | (in_data & (bit_cnt_reg == slot));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg   <= '0;
      col_cnt_reg   <= '0;
      shift_reg     <= '0;
      out_data_reg  <= '0;
      out_ready_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (!in_enable) begin
      // Idle drops any partial word and restarts the line at column 0.
      bit_cnt_reg   <= '0;
      col_cnt_reg   <= '0;
      shift_reg     <= '0;
      out_data_reg  <= '0;
      out_ready_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      col_cnt_reg <= line_done ? '0 : col_cnt_reg + col_w'(1);
      if (word_done) begin
        bit_cnt_reg   <= '0;
        shift_reg     <= '0;
        out_data_reg  <= word_next;
        out_ready_reg <= 1'b1;
        out_last_reg  <= line_done;
      end else begin
        bit_cnt_reg   <= bit_cnt_reg + bit_w'(1);
        shift_reg     <= word_next;
        out_data_reg  <= '0;
        out_ready_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign out_ready = out_ready_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_binary_packer.sv
// Directed bench for binary_packer: LSB-first, MSB-first and pack_width=1 instances
// driven from one sequence of scenario tasks.
module tb_binary_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, d0 = 1'b0, en1 = 1'b0, d1 = 1'b0, en2 = 1'b0, d2 = 1'b0;
  logic r0, r1, r2, l0, l1, l2;
  logic [7:0] q0, q1;
  logic [0:0] q2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  binary_packer #(.pack_width(8), .line_width(20), .msb_first(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_enable(en0), .in_data(d0),
    .out_ready(r0), .out_data(q0), .out_last(l0));

  binary_packer #(.pack_width(8), .line_width(20), .msb_first(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_enable(en1), .in_data(d1),
    .out_ready(r1), .out_data(q1), .out_last(l1));

  binary_packer #(.pack_width(1), .line_width(4), .msb_first(1'b0)) dut_one (
    .clk(clk), .rst_n(rst_n), .in_enable(en2), .in_data(d2),
    .out_ready(r2), .out_data(q2), .out_last(l2));

  // Drive one pixel (or idle) into the selected instance, then wait past the edge.
  task automatic step(input int sel, input logic e, input logic d);
    en0 = (sel == 0) && e; d0 = (sel == 0) && d;
    en1 = (sel == 1) && e; d1 = (sel == 1) && d;
    en2 = (sel == 2) && e; d2 = (sel == 2) && d;
    @(posedge clk);
    #1;
  endtask

  task automatic get(input int sel, output logic rdy, output logic [7:0] dat, output logic lst);
    case (sel)
      0:       begin rdy = r0; dat = q0;          lst = l0; end
      1:       begin rdy = r1; dat = q1;          lst = l1; end
      default: begin rdy = r2; dat = {7'b0, q2};  lst = l2; end
    endcase
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    total++;
    if ({r0, q0, l0, r1, q1, l1, r2, q2, l2} !== 21'b0) begin
      $display("FAIL reset_outputs: got %b want all zero", {r0, q0, l0, r1, q1, l1, r2, q2, l2});
      bad++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({r0, r1, r2} !== 3'b000) begin
      $display("FAIL reset_release_ready: got %b want 000", {r0, r1, r2});
      bad++;
    end
  endtask

  // Pattern 1,0,1,1,0,0,0,0 then in_enable drops right after the word completes.
  task automatic test_basic_pack(input int sel, input logic [7:0] exp_word, input string name);
    logic [7:0] pat = 8'b0000_1101;
    logic rdy, lst;
    logic [7:0] dat;
    for (int i = 0; i < 8; i++) begin
      step(sel, 1'b1, pat[i]);
      get(sel, rdy, dat, lst);
      total++;
      if (i < 7 && {rdy, dat, lst} !== 10'b0) begin
        $display("FAIL %s_early px%0d: got r=%b d=%h l=%b want r=0 d=00 l=0", name, i, rdy, dat, lst);
        bad++;
      end else if (i == 7 && {rdy, dat, lst} !== {1'b1, exp_word, 1'b0}) begin
        $display("FAIL %s_word: got r=%b d=%h l=%b want r=1 d=%h l=0", name, rdy, dat, lst, exp_word);
        bad++;
      end
    end
    step(sel, 1'b0, 1'b0);
    get(sel, rdy, dat, lst);
    total++;
    if ({rdy, dat, lst} !== 10'b0) begin
      $display("FAIL %s_drop: got r=%b d=%h l=%b want r=0 d=00 l=0", name, rdy, dat, lst);
      bad++;
    end
  endtask

  // n ones into a line_width=20, pack_width=8 instance; checked every cycle.
  task automatic test_stream(input int sel, input int n, input logic [7:0] tail_word,
                             input int exp_pulses, input string name);
    logic rdy, lst, exp_r, exp_l;
    logic [7:0] dat, exp_d;
    int col;
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(sel, 1'b1, 1'b1);
      get(sel, rdy, dat, lst);
      col   = i % 20;
      exp_r = (col == 7) || (col == 15) || (col == 19);
      exp_l = (col == 19);
      exp_d = !exp_r ? 8'h00 : (col == 19 ? tail_word : 8'hFF);
      if (rdy === 1'b1) pulses++;
      total++;
      if ({rdy, dat, lst} !== {exp_r, exp_d, exp_l}) begin
        $display("FAIL %s px%0d: got r=%b d=%h l=%b want r=%b d=%h l=%b",
                 name, i, rdy, dat, lst, exp_r, exp_d, exp_l);
        bad++;
      end
    end
    total++;
    if (pulses != exp_pulses) begin
      $display("FAIL %s_pulses: got %0d want %0d", name, pulses, exp_pulses);
      bad++;
    end
    step(sel, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) begin
      step(0, i < 5, 1'b1);
      total++;
      if ({r0, q0, l0} !== 10'b0) begin
        $display("FAIL abort_quiet c%0d: got r=%b d=%h l=%b want r=0 d=00 l=0", i, r0, q0, l0);
        bad++;
      end
    end
    test_stream(0, 20, 8'h0F, 3, "abort_restart");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b1);
    total++;
    if ({r0, q0, l0} !== {1'b1, 8'hFF, 1'b0}) begin
      $display("FAIL areset_pre: got r=%b d=%h l=%b want r=1 d=ff l=0", r0, q0, l0);
      bad++;
    end
    en0 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({r0, q0, l0} !== 10'b0) begin
      $display("FAIL areset_immediate: got r=%b d=%h l=%b want r=0 d=00 l=0", r0, q0, l0);
      bad++;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1);
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, 1'b1);
      total++;
      if (i < 7 && r0 !== 1'b0) begin
        $display("FAIL areset_midword px%0d: got r=%b want r=0", i, r0);
        bad++;
      end else if (i == 7 && {r0, q0, l0} !== {1'b1, 8'hFF, 1'b0}) begin
        $display("FAIL areset_word: got r=%b d=%h l=%b want r=1 d=ff l=0", r0, q0, l0);
        bad++;
      end
    end
    step(0, 1'b0, 1'b0);
  endtask

  task automatic test_degenerate();
    logic [3:0] pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(2, 1'b1, pat[i]);
      total++;
      if ({r2, q2, l2} !== {1'b1, pat[i], i == 3}) begin
        $display("FAIL width1 px%0d: got r=%b d=%b l=%b want r=1 d=%b l=%b",
                 i, r2, q2, l2, pat[i], i == 3);
        bad++;
      end
    end
    step(2, 1'b0, 1'b0);
    total++;
    if ({r2, q2, l2} !== 3'b000) begin
      $display("FAIL width1_idle: got r=%b d=%b l=%b want r=0 d=0 l=0", r2, q2, l2);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack(0, 8'h0D, "basic_lsb");
    test_basic_pack(1, 8'hB0, "basic_msb");
    test_stream(0, 20, 8'h0F, 3, "flush_lsb");
    test_stream(1, 20, 8'hF0, 3, "flush_msb");
    test_stream(0, 40, 8'h0F, 6, "two_lines");
    test_abort();
    test_async_reset();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_packer.md
Name: binary_packer

Overview:
- Consumes the 1-bit binary pixel stream produced by the thresholding stage (in_enable / in_data, one pixel per clk while in_enable is high).
- Packs consecutive pixels into pack_width-bit words for storage or transport.
- Tracks the column position and flushes a zero-padded partial word at the end of each line.
- Sits between the point-processing binarisation stage and the frame/line buffer writer.

Parameters:
- pack_width, 8, bits per output word; legal range 1..32.
- line_width, 640, pixels per image line; legal range 1..4096.
- msb_first, 0, 0 = first pixel of a word goes to bit 0; 1 = first pixel goes to bit pack_width-1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_enable  input  1  stream active; a pixel is accepted on every posedge clk while high.
- in_data  input  1  binary pixel.
- out_ready  output  1  one-cycle pulse; out_data and out_last are valid while high.
- out_data  output  pack_width  packed word; forced to 0 whenever out_ready is 0.
- out_last  output  1  high with out_ready when the word holds the last pixel of a line; 0 otherwise.

Behaviour:
- Reset (rst_n low, asynchronous):
  - bit counter, column counter, shift register and output register clear to 0.
  - out_ready = 0, out_data = 0, out_last = 0.
- Idle (posedge clk with in_enable low):
  - Counters and shift register clear synchronously; no pixel is accepted.
  - out_ready = 0 from that edge on.
  - A partial word in progress is discarded, never emitted.
- Accept (posedge clk with in_enable high):
  - in_data is written at bit index bit_cnt, or pack_width-1-bit_cnt when msb_first = 1.
  - bit_cnt and col_cnt increment.
- Word complete, when the accepted pixel has bit_cnt == pack_width-1 or col_cnt == line_width-1:
  - On the same edge the assembled word, including the current pixel, is loaded into the output register.
  - Unfilled bit positions are 0: high bits when msb_first = 0, low bits when msb_first = 1.
  - out_ready = 1 for exactly the following cycle; out_last = 1 if col_cnt == line_width-1.
  - bit_cnt returns to 0.
- Line wrap:
  - col_cnt wraps from line_width-1 to 0 on the same edge.
  - The next line always starts a fresh word; no packing across lines.
- Latency: one clk from the edge that samples the last bit of a word to out_ready high.
- Back-to-back operation:
  - The next word's first pixel may be accepted on the same edge that loads the previous word. No stall; full rate is sustained.
  - A full word completing on consecutive edges is legal when pack_width = 1, giving out_ready high continuously.
- in_enable falling in the cycle after a word completed:
  - The registered word is still presented for that one cycle (out_ready = 1).
  - Counters clear on the next edge.
- Output registers hold no stale data: out_data and out_last read 0 whenever out_ready is 0.
- Widths: the counters are sized internally to hold pack_width-1 and line_width-1; no other arithmetic.

Test Plan:
- Basic pack (pack_width 8, msb_first 0): bits 1,0,1,1,0,0,0,0 on 8 consecutive cycles -> one out_ready pulse on the 9th cycle with out_data = 0x0D, out_last = 0.
- Line flush (line_width 20): 20 ones -> three pulses, 8 and 8 and 4 cycles apart, data 0xFF, 0xFF, 0x0F; out_last = 1 on the third only.
- Repeat the line-flush test with msb_first = 1 -> third word = 0xF0.
- Continuous two lines (40 ones, line_width 20) -> six pulses with no dropped pixel; out_last on the 3rd and 6th pulses; col wrap verified.
- Abort: in_enable high for 5 pixels then low for 3 cycles, then 8 ones -> no output for the aborted pixels; next word = 0xFF and is not marked last (column restarted at 0).
- Async reset mid-word: assert rst_n low after 3 pixels, asynchronously to clk -> out_ready, out_data and out_last go 0 immediately; after release, the first full word of 8 ones is emitted as 0xFF.
- Degenerate pack_width 1, line_width 4: pattern 1,0,1,1 -> out_ready high 4 consecutive cycles with data 1,0,1,1 and out_last on the 4th.
